// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read bypass).
package regfile_pkg;
  localparam int DEF_WORD       = 4;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DW         = DEF_WORD * DEF_WIDTH;

  // PC lives in the top register index; fetch advances by one word
  localparam int PC_IDX = (1 << DEF_ADDR_WIDTH) - 1;
  localparam int PC_INC = 4;

  typedef logic [DEF_DW-1:0]         word_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

  // PC index for an arbitrary address width
  function automatic int pc_index(input int aw);
    return (1 << aw) - 1;
  endfunction
endpackage

// File: rtl/regfile_pc.sv
// Program counter next-state and the registered fetch address (iout).
// A write to the PC index overrides stall/branch; arithmetic wraps silently.
module regfile_pc
  import regfile_pkg::*;
#(
  parameter int             DW       = 32,
  parameter logic [DW-1:0]  PC_RESET = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          ib,
  input  logic [DW-1:0] bv,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_val,
  output logic [DW-1:0] pc_o,
  output logic [DW-1:0] iout_o
);
  logic [DW-1:0] pc_q, pc_d, iout_q, iout_d;

  // Next PC: write > stall > branch > sequential
  always_comb begin
    pc_d   = pc_q + DW'(PC_INC);
    iout_d = pc_q;
    if (wr_en)      pc_d = wr_val;
    else if (stall) pc_d = pc_q;
    else if (ib)    pc_d = pc_q + bv;
    if (stall)      iout_d = iout_q;
  end

  // PC and fetch-address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= PC_RESET;
      iout_q <= '0;
    end else begin
      pc_q   <= pc_d;
      iout_q <= iout_d;
    end
  end

  assign pc_o   = pc_q;
  assign iout_o = iout_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD registered reads, NWRITE byte-enabled
// writes (higher port wins per byte), busy scoreboard, PC in the top index.
// Optional feature macro: REGFILE_BYPASS_EN -- reads see same-edge writes/clears.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WORD       = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 2,
  parameter logic [WORD*WIDTH-1:0] PC_RESET = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREAD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NREAD*WORD*WIDTH-1:0]   rd_data,
  output logic [NREAD-1:0]              rd_busy,
  input  logic [NWRITE-1:0]             we,
  input  logic [NWRITE*ADDR_WIDTH-1:0]  wa,
  input  logic [NWRITE*WORD*WIDTH-1:0]  wd,
  input  logic [NWRITE*WORD-1:0]        wbe,
  input  logic                          iss_valid,
  input  logic [ADDR_WIDTH-1:0]         iss_addr,
  input  logic                          stall,
  input  logic                          ib,
  input  logic [WORD*WIDTH-1:0]         bv,
  output logic [WORD*WIDTH-1:0]         iout
);
  localparam int DW   = WORD * WIDTH;
  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int PCI  = pc_index(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] PCI_A = ADDR_WIDTH'(PCI);

  logic [NREG-2:0][DW-1:0]  mem_q;
  logic [NREG-1:0][DW-1:0]  cur, nxt;
  logic [NREG-1:0]          busy_q, busy_d, clr, set;
  logic                     pc_wr;
  logic [DW-1:0]            pc;
  logic [NREAD-1:0][DW-1:0] rd_data_q, rd_data_d;
  logic [NREAD-1:0]         rd_busy_q, rd_busy_d;

  // Architectural view: general registers from storage, top index is the PC
  for (genvar r = 0; r < NREG - 1; r++) begin : g_cur
    assign cur[r] = mem_q[r];
  end
  assign cur[PCI] = pc;

  // Per-byte write merge, ascending port order so the highest port wins
  always_comb begin
    nxt   = cur;
    clr   = '0;
    pc_wr = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j] && |wbe[j*WORD +: WORD]) begin
        clr[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        if (wa[j*ADDR_WIDTH +: ADDR_WIDTH] == PCI_A) pc_wr = 1'b1;
      end
      for (int b = 0; b < WORD; b++)
        if (we[j] && wbe[j*WORD + b])
          nxt[wa[j*ADDR_WIDTH +: ADDR_WIDTH]][b*WIDTH +: WIDTH] = wd[j*DW + b*WIDTH +: WIDTH];
    end
  end

  // Scoreboard: writes clear, issue sets (set wins), PC never busy
  always_comb begin
    set = '0;
    if (iss_valid && iss_addr != PCI_A) set[iss_addr] = 1'b1;
    busy_d      = (busy_q & ~clr) | set;
    busy_d[PCI] = 1'b0;
  end

  // Read ports; the PC index always returns the pre-update PC and not-busy
  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int i = 0; i < NREAD; i++) begin
`ifdef REGFILE_BYPASS_EN
      rd_data_d[i] = nxt[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      rd_busy_d[i] = busy_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] & ~clr[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`else
      rd_data_d[i] = cur[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      rd_busy_d[i] = busy_q[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
      if (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == PCI_A) begin
        rd_data_d[i] = pc;
        rd_busy_d[i] = 1'b0;
      end
    end
  end

  // Storage, scoreboard and read-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      mem_q     <= nxt[NREG-2:0];
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  regfile_pc #(.DW(DW), .PC_RESET(PC_RESET)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .stall  (stall),
    .ib     (ib),
    .bv     (bv),
    .wr_en  (pc_wr),
    .wr_val (nxt[PCI]),
    .pc_o   (pc),
    .iout_o (iout)
  );

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// against a word/byte-level reference model of the register file.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  we;
  logic [7:0]  wa;
  logic [63:0] wd;
  logic [7:0]  wbe;
  logic        iss_valid;
  logic [3:0]  iss_addr;
  logic        stall, ib;
  logic [31:0] bv, iout;

  int total = 0, bad = 0;

  // reference model state
  word_t m_reg [16];
  bit    m_busy[16];
  word_t m_pc, m_iout;
  word_t m_rd[2];
  bit    m_rb[2];

  regfile_mp #(.WORD(4), .WIDTH(8), .ADDR_WIDTH(4), .NREAD(2), .NWRITE(2),
               .PC_RESET(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .stall(stall), .ib(ib),
    .bv(bv), .iout(iout));

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int r = 0; r < 16; r++) begin m_reg[r] = '0; m_busy[r] = 0; end
    m_pc = 32'h100; m_iout = '0;
    for (int i = 0; i < 2; i++) begin m_rd[i] = '0; m_rb[i] = 0; end
  endfunction

  // one clock edge of the specified behaviour, from the current inputs
  function automatic void model_edge();
    word_t cur[16], nr[16];
    bit    aclr[16];
    bit    pcw;
    int    a;
    pcw = 0;
    for (int r = 0; r < 16; r++) begin
      cur[r]  = (r == PC_IDX) ? m_pc : m_reg[r];
      nr[r]   = cur[r];
      aclr[r] = m_busy[r];
    end
    for (int j = 0; j < 2; j++) if (we[j]) begin
      a = int'(wa[j*4 +: 4]);
      for (int b = 0; b < 4; b++)
        if (wbe[j*4 + b]) nr[a][b*8 +: 8] = wd[j*32 + b*8 +: 8];
      if (wbe[j*4 +: 4] != 4'h0) begin
        aclr[a] = 0;
        if (a == PC_IDX) pcw = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      a = int'(rd_addr[i*4 +: 4]);
      if (a == PC_IDX) begin m_rd[i] = m_pc; m_rb[i] = 0; end
      else begin
`ifdef REGFILE_BYPASS_EN
        m_rd[i] = nr[a]; m_rb[i] = aclr[a];
`else
        m_rd[i] = cur[a]; m_rb[i] = m_busy[a];
`endif
      end
    end
    for (int r = 0; r < 16; r++) m_busy[r] = aclr[r];
    if (iss_valid && int'(iss_addr) != PC_IDX) m_busy[iss_addr] = 1;
    if (!stall) m_iout = m_pc;
    if (pcw)        m_pc = nr[PC_IDX];
    else if (stall) m_pc = m_pc;
    else if (ib)    m_pc = m_pc + bv;
    else            m_pc = m_pc + 32'd4;
    for (int r = 0; r < 15; r++) m_reg[r] = nr[r];
  endfunction

  task automatic idle();
    we = '0; wa = '0; wd = '0; wbe = '0; iss_valid = 0; iss_addr = '0;
    stall = 0; ib = 0; bv = '0; rd_addr = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic set_wr(input int j, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    we[j] = 1'b1; wa[j*4 +: 4] = a; wd[j*32 +: 32] = d; wbe[j*4 +: 4] = be;
  endtask

  task automatic test_reset();
    idle(); model_reset();
    rd_addr = 8'h53;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_rd_busy got=%b exp=00", rd_busy); end
    total++; if (iout !== 32'h0) begin bad++; $display("FAIL reset_iout got=%h exp=0", iout); end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (iout !== 32'h100 + 32'(4*k)) begin bad++; $display("FAIL reset_seq%0d iout got=%h exp=%h", k, iout, 32'h100 + 32'(4*k)); end
    end
  endtask

  task automatic test_merge();
    idle(); set_wr(0, 4'd3, 32'h11223344, 4'hF); tick();
    idle(); set_wr(0, 4'd3, 32'hAAAAAAAA, 4'hF); set_wr(1, 4'd3, 32'h000000BB, 4'h1); tick();
    idle(); rd_addr = 8'h33; tick();
    total++; if (rd_data[31:0] !== 32'hAAAAAABB) begin bad++; $display("FAIL merge_p0 got=%h exp=aaaaaabb", rd_data[31:0]); end
    total++; if (rd_data[63:32] !== 32'hAAAAAABB) begin bad++; $display("FAIL merge_p1 got=%h exp=aaaaaabb", rd_data[63:32]); end
  endtask

  task automatic test_scoreboard();
    idle(); iss_valid = 1; iss_addr = 4'd5; tick();
    idle(); rd_addr = 8'h05; tick();
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_issue busy got=%b exp=1", rd_busy[0]); end
    idle(); set_wr(0, 4'd5, 32'd7, 4'hF); iss_valid = 1; iss_addr = 4'd5; tick();
    idle(); rd_addr = 8'h05; tick();
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_set_wins busy got=%b exp=1", rd_busy[0]); end
    total++; if (rd_data[31:0] !== 32'd7) begin bad++; $display("FAIL sb_data got=%h exp=7", rd_data[31:0]); end
    idle(); set_wr(1, 4'd5, 32'd9, 4'hF); tick();
    idle(); rd_addr = 8'h50; tick();
    total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL sb_clear busy got=%b exp=0", rd_busy[1]); end
    total++; if (rd_data[63:32] !== 32'd9) begin bad++; $display("FAIL sb_data2 got=%h exp=9", rd_data[63:32]); end
    // a write with no byte enables neither stores nor clears busy
    idle(); iss_valid = 1; iss_addr = 4'd6; tick();
    idle(); set_wr(0, 4'd6, 32'hFFFF, 4'h0); tick();
    idle(); rd_addr = 8'h06; tick();
    total++; if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL sb_nowbe got=%b/%h exp=1/0", rd_busy[0], rd_data[31:0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d;
    logic        exp_b;
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'hDEAD; exp_b = 1'b0;
`else
    exp_d = 32'h1111; exp_b = 1'b1;
`endif
    idle(); set_wr(0, 4'd2, 32'h1111, 4'hF); tick();
    idle(); iss_valid = 1; iss_addr = 4'd2; tick();
    idle(); set_wr(0, 4'd2, 32'hDEAD, 4'hF); rd_addr = 8'h02; tick();
    total++; if (rd_data[31:0] !== exp_d) begin bad++; $display("FAIL bypass_data got=%h exp=%h", rd_data[31:0], exp_d); end
    total++; if (rd_busy[0] !== exp_b) begin bad++; $display("FAIL bypass_busy got=%b exp=%b", rd_busy[0], exp_b); end
    idle(); rd_addr = 8'h02; tick();
    total++; if (rd_data[31:0] !== 32'hDEAD || rd_busy[0] !== 1'b0) begin bad++; $display("FAIL bypass_after got=%h/%b exp=dead/0", rd_data[31:0], rd_busy[0]); end
  endtask

  task automatic test_pc();
    logic [31:0] held;
    idle(); set_wr(0, 4'd15, 32'h200, 4'hF); iss_valid = 1; iss_addr = 4'd15; tick();
    idle(); ib = 1; bv = 32'hFFFFFFF8; tick();
    total++; if (iout !== 32'h200) begin bad++; $display("FAIL pc_at200 iout got=%h exp=200", iout); end
    idle(); rd_addr = 8'hF0; tick();
    total++; if (iout !== 32'h1F8) begin bad++; $display("FAIL pc_branch iout got=%h exp=1f8", iout); end
    total++; if (rd_data[63:32] !== 32'h1F8 || rd_busy[1] !== 1'b0) begin bad++; $display("FAIL pc_read got=%h/%b exp=1f8/0", rd_data[63:32], rd_busy[1]); end
    held = iout;
    idle(); stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (iout !== held) begin bad++; $display("FAIL pc_stall%0d iout got=%h exp=%h", k, iout, held); end
    end
    idle(); set_wr(1, 4'd15, 32'h40, 4'hF); ib = 1; bv = 32'h100; tick();
    idle(); tick();
    total++; if (iout !== 32'h40) begin bad++; $display("FAIL pc_wr_over_ib iout got=%h exp=40", iout); end
  endtask

  task automatic test_wrap();
    idle(); set_wr(1, 4'd15, 32'hFFFFFFFC, 4'hF); tick();
    idle(); tick();
    total++; if (iout !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_pre iout got=%h exp=fffffffc", iout); end
    tick();
    total++; if (iout !== 32'h0) begin bad++; $display("FAIL wrap iout got=%h exp=0", iout); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we        = 2'($urandom);
      wa        = 8'($urandom);
      wd        = {$urandom, $urandom};
      wbe       = 8'($urandom);
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = 4'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      ib        = ($urandom_range(0, 3) == 0);
      bv        = $urandom;
      rd_addr   = 8'($urandom);
      tick();
      total++;
      if (rd_data !== {m_rd[1], m_rd[0]} || rd_busy !== {m_rb[1], m_rb[0]} || iout !== m_iout) begin
        bad++;
        $display("FAIL rand%0d got=%h/%b/%h exp=%h%h/%b%b/%h", n, rd_data, rd_busy, iout, m_rd[1], m_rd[0], m_rb[1], m_rb[0], m_iout);
      end
    end
  endtask

  task automatic test_async_reset();
    idle(); set_wr(0, 4'd1, 32'h55, 4'hF); rd_addr = 8'hF1; tick();
    idle(); @(posedge clk); #3;
    rst_n = 1'b0; #1;
    total++; if (rd_data !== 64'h0 || rd_busy !== 2'b00 || iout !== 32'h0) begin bad++; $display("FAIL async_reset got=%h/%b/%h exp=0", rd_data, rd_busy, iout); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_addr = 8'h01; tick();
    total++; if (iout !== 32'h100 || rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL async_release got=%h/%h exp=100/0", iout, rd_data[31:0]); end
  endtask

  initial begin
    test_reset();
    test_merge();
    test_scoreboard();
    test_bypass();
    test_pc();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next generation of the CPU's integer register file. It provides NREAD registered read ports and NWRITE byte-enabled write-back ports (ALU plus load path, including ldrb). Register r(2^ADDR_WIDTH−1) is the program counter, with stall and branch control. A per-register busy scoreboard lets decode detect pending writes. The block sits between decode (reads/issue) and write-back, and feeds fetch via iout.

## Interface
- WORD, 4, bytes per register
- WIDTH, 8, bits per byte
- ADDR_WIDTH, 4, register address bits; NREG = 2^ADDR_WIDTH, PC index = NREG−1
- NREAD, 2, read ports
- NWRITE, 2, write ports; higher index has higher priority
- PC_RESET, 0, PC value after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NREAD*ADDR_WIDTH  read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NREAD*WORD*WIDTH  registered read data
- rd_busy  out  NREAD  registered busy flag for each read
- we  in  NWRITE  write enables
- wa  in  NWRITE*ADDR_WIDTH  write addresses
- wd  in  NWRITE*WORD*WIDTH  write data
- wbe  in  NWRITE*WORD  byte enables; byte b of port j is written only if wbe[j*WORD+b]
- iss_valid  in  1  mark iss_addr busy (instruction issued with that destination)
- iss_addr  in  ADDR_WIDTH  destination being issued
- stall  in  1  hold PC and iout
- ib  in  1  branch: PC advances by bv instead of 4
- bv  in  WORD*WIDTH  branch offset, two's complement
- iout  out  WORD*WIDTH  registered PC for fetch

## Operation
- Reset (async, rst_n=0): all registers 0, PC=PC_RESET, busy all 0, rd_data=0, rd_busy=0, iout=0.
- Write, per byte: the highest-index port j with we[j], wa[j]==addr and wbe[j*WORD+b] writes byte b. Bytes with no enabled writer hold their value.
- PC next-state priority, highest first:
  - any write to the PC index (a full-word or partial merge over the current PC);
  - stall: hold;
  - ib: PC+bv;
  - otherwise PC+4.
- All PC arithmetic is modulo 2^(WORD*WIDTH) and wraps silently.
- iout ← current PC each cycle unless stall=1, in which case it holds.
- Scoreboard:
  - any write (we[j] with at least one wbe bit set) clears busy[wa[j]];
  - iss_valid sets busy[iss_addr];
  - set wins over clear on the same address in the same cycle;
  - iss_addr==PC index is ignored, so the PC is never busy.
- Read: rd_data[i] ← value of rd_addr[i]; rd_busy[i] ← busy of rd_addr[i]. The pre-/post-write view of both is selected by configuration.
- A read of the PC index returns the current (pre-update) PC, with busy 0.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and the data is valid after edge N.
- Write latency is 1 cycle: data is visible to a read sampled at edge N+1, or at edge N with bypass.
- Issue sets busy, visible to a read sampled at edge N+1.
- There is no handshake. Inputs are sampled every rising edge, and stall affects only PC/iout.
- Reset asserted mid-cycle clears all state immediately. The first PC update happens at the first edge after rst_n rises.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read sampled on the same edge as a write to the same address returns the merged new bytes and rd_busy reflecting the clear;
  - a same-edge issue is still not visible.
- REGFILE_BYPASS_EN undefined:
  - the read returns the old value and the old busy flag, so the consumer sees busy=1 and re-reads;
  - no write→read combinational path exists.

## Structure
- regfile_pkg holds:
  - word_t and reg_addr_t typedefs;
  - the PC_IDX constant;
  - the PC_INC=4 constant.
- Sub-module regfile_pc implements PC next-state (write override, stall, ib, +4) and the iout register.
- Storage, write merge, scoreboard and read ports stay in regfile_mp.

## Test plan
- Reset with PC_RESET=0x100, release, no stall → iout = 0x100, 0x104, 0x108 on successive cycles; all rd_data and rd_busy = 0 during reset.
- Two-port byte merge:
  - stimulus: r3=0x11223344, then we=2'b11 to r3 in one cycle, wd0=0xAAAAAAAA with wbe0=4'b1111, wd1=0x000000BB with wbe1=4'b0001;
  - required: next read of r3 = 0xAAAAAABB.
- Scoreboard:
  - issue r5 → read r5 next cycle gives rd_busy=1;
  - write r5=7 together with iss_valid on r5 → busy stays 1;
  - a later write alone → busy 0.
- Bypass:
  - stimulus: write r2=0xDEAD and read r2 on the same edge;
  - required with REGFILE_BYPASS_EN: rd_data=0xDEAD; without it: the old value.
- PC control:
  - at PC=0x200, ib=1, bv=0xFFFFFFF8 → PC 0x1F8;
  - stall=1 for 3 cycles → iout constant;
  - write r15=0x40 concurrent with ib → PC 0x40.
- PC wrap: PC=0xFFFFFFFC, no branch → PC 0x00000000.
